ascii_line_loader: RTL and testbench

Upstream feeder for the Puzzle 3 part-2 joltage core. Consumes the puzzle input as an ASCII byte stream, one character per accepted beat, and accumulates each line's decimal digits into an `IN_WIDTH`-bit binary value. On end-of-line it hands the value to the downstream core through a one-line output buffer with a `start`/`done` handshake. While the downstream core is working on one line, the block continues parsing the next one.

---
 rtl/puzzle3_pkg.sv | 27 ++
 rtl/mul10_add.sv | 18 +
 rtl/ascii_line_loader.sv | 158 +++++++++++++++
 tb/tb_ascii_line_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/puzzle3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : puzzle3_pkg
// Purpose  : Shared constants and FSM state encodings for the Puzzle 3 loader.
// Revision : 1.0 - initial release
// ============================================================================
package puzzle3_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int DEF_IN_WIDTH   = 336;
    localparam int DEF_NUM_DIGITS = 100;

    typedef enum logic [0:0] {
        PARSE = 1'b0,
        HOLD  = 1'b1
    } parse_state_e;

    typedef enum logic [0:0] {
        DS_IDLE = 1'b0,
        DS_BUSY = 1'b1
    } ds_state_e;

endpackage
`default_nettype wire

// File: rtl/mul10_add.sv
`default_nettype none
// ============================================================================
// Module   : mul10_add
// Purpose  : Combinational y = x*10 + d, truncated to W bits (shift-add form).
// Revision : 1.0 - initial release
// ============================================================================
module mul10_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [3:0]   d,
    output logic [W-1:0] y
);

    assign y = (x << 3) + (x << 1) + W'(d);

endmodule
`default_nettype wire

// File: rtl/ascii_line_loader.sv
`default_nettype none
// ============================================================================
// Module   : ascii_line_loader
// Purpose  : Parses ASCII decimal lines into binary values and hands them to a
//            downstream core through a one-line buffer with start/done.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_line_loader
    import puzzle3_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_char,
    output logic                 in_ready,
    output logic [IN_WIDTH-1:0]  out_num,
    output logic                 out_start,
    input  logic                 ds_done,
    output logic [CNT_WIDTH-1:0] lines_sent,
    output logic [CNT_WIDTH-1:0] lines_dropped
);

    localparam int                DCNT_W   = $clog2(NUM_DIGITS + 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(NUM_DIGITS);

    parse_state_e         parse_q, parse_d;
    ds_state_e            ds_q, ds_d;
    logic [IN_WIDTH-1:0]  acc_q, acc_d;
    logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
    logic                 ovf_q, ovf_d;
    logic [IN_WIDTH-1:0]  out_num_q, out_num_d;
    logic                 out_start_q, out_start_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic [CNT_WIDTH-1:0] dropped_q, dropped_d;

    logic [IN_WIDTH-1:0]  acc_next;
    logic                 accept;
    logic                 is_digit;
    logic                 is_lf;
    logic                 buf_free;
    logic                 issue;
    logic                 clear_line;

    // The low nibble of '0'..'9' is the digit value itself.
    mul10_add #(
        .W (IN_WIDTH)
    ) u_mul10_add (
        .x (acc_q),
        .d (in_char[3:0]),
        .y (acc_next)
    );

    assign in_ready = (parse_q == PARSE);
    assign accept   = in_valid && in_ready;
    assign is_digit = (in_char >= ASCII_ZERO) && (in_char <= ASCII_NINE);
    assign is_lf    = (in_char == ASCII_LF);
    // A done arriving with the LF frees the buffer in the same cycle.
    assign buf_free = (ds_q == DS_IDLE) || ds_done;

    always_comb begin
        parse_d     = parse_q;
        ds_d        = ds_q;
        acc_d       = acc_q;
        dcnt_d      = dcnt_q;
        ovf_d       = ovf_q;
        out_num_d   = out_num_q;
        out_start_d = 1'b0;
        sent_d      = sent_q;
        dropped_d   = dropped_q;
        issue       = 1'b0;
        clear_line  = 1'b0;

        if (ds_q == DS_BUSY && ds_done) begin
            ds_d = DS_IDLE;
        end

        if (parse_q == HOLD) begin
            if (ds_done) begin
                issue      = 1'b1;
                clear_line = 1'b1;
                parse_d    = PARSE;
            end
        end else if (accept) begin
            if (is_digit) begin
                if (dcnt_q == DCNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    acc_d  = acc_next;
                    dcnt_d = dcnt_q + 1'b1;
                end
            end else if (is_lf) begin
                if (dcnt_q == '0) begin
                    clear_line = 1'b1;
                end else if (ovf_q) begin
                    clear_line = 1'b1;
                    if (dropped_q != '1) begin
                        dropped_d = dropped_q + 1'b1;
                    end
                end else if (buf_free) begin
                    issue      = 1'b1;
                    clear_line = 1'b1;
                end else begin
                    parse_d = HOLD;
                end
            end
        end

        if (issue) begin
            out_num_d   = acc_q;
            out_start_d = 1'b1;
            ds_d        = DS_BUSY;
            if (sent_q != '1) begin
                sent_d = sent_q + 1'b1;
            end
        end

        if (clear_line) begin
            acc_d  = '0;
            dcnt_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parse_q     <= PARSE;
            ds_q        <= DS_IDLE;
            acc_q       <= '0;
            dcnt_q      <= '0;
            ovf_q       <= 1'b0;
            out_num_q   <= '0;
            out_start_q <= 1'b0;
            sent_q      <= '0;
            dropped_q   <= '0;
        end else begin
            parse_q     <= parse_d;
            ds_q        <= ds_d;
            acc_q       <= acc_d;
            dcnt_q      <= dcnt_d;
            ovf_q       <= ovf_d;
            out_num_q   <= out_num_d;
            out_start_q <= out_start_d;
            sent_q      <= sent_d;
            dropped_q   <= dropped_d;
        end
    end

    assign out_num       = out_num_q;
    assign out_start     = out_start_q;
    assign lines_sent    = sent_q;
    assign lines_dropped = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_ascii_line_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascii_line_loader
// Purpose  : Directed self-checking bench for ascii_line_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascii_line_loader;

    localparam int W  = 336;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_char;
    logic          in_ready;
    logic [W-1:0]  out_num;
    logic          out_start;
    logic          ds_done = 1'b0;
    logic [CW-1:0] lines_sent;
    logic [CW-1:0] lines_dropped;

    int            n_total = 0;
    int            n_pass  = 0;
    logic [W-1:0]  pulse_vals[$];
    int            ds_delay    = 20;
    int            ds_cnt      = 0;
    int            timing_base = -1;
    logic          ds_done_seen = 1'b0;
    logic [W-1:0]  prev_num;

    ascii_line_loader #(
        .IN_WIDTH   (W),
        .NUM_DIGITS (100),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_char       (in_char),
        .in_ready      (in_ready),
        .out_num       (out_num),
        .out_start     (out_start),
        .ds_done       (ds_done),
        .lines_sent    (lines_sent),
        .lines_dropped (lines_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // What the DUT sampled as ds_done at the most recent rising edge.
    always @(posedge clk) ds_done_seen <= ds_done;

    // Downstream model: done pulse ds_delay cycles after each start.
    always @(negedge clk) begin
        if (ds_done) ds_done = 1'b0;
        if (out_start) begin
            ds_cnt = ds_delay;
        end else if (ds_cnt > 0) begin
            ds_cnt--;
            if (ds_cnt == 0) ds_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (out_start) begin
            if (timing_base >= 0 && pulse_vals.size() > timing_base)
                check("start_after_done", W'(ds_done_seen), W'(1));
            pulse_vals.push_back(out_num);
        end else if (!rst && out_num !== prev_num) begin
            check("out_num_stable", out_num, prev_num);
        end
        prev_num = out_num;
    end

    task automatic send(input logic [7:0] c);
        int guard = 0;
        in_char  = c;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", W'(in_ready), W'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic send_rep(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) send(c);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        logic [W-1:0] nines;
        int           base;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready",  W'(in_ready),      W'(1));
        check("rst_out_start", W'(out_start),     W'(0));
        check("rst_out_num",   out_num,           W'(0));
        check("rst_sent",      W'(lines_sent),    W'(0));
        check("rst_dropped",   W'(lines_dropped), W'(0));

        base = pulse_vals.size();
        send_str("987654321111111\n");
        check("t1_start", W'(out_start), W'(1));
        check("t1_num",   out_num,       W'(64'd987654321111111));
        repeat (25) @(negedge clk);
        check("t1_pulses", W'(pulse_vals.size() - base), W'(1));
        check("t1_sent",   W'(lines_sent),               W'(1));

        base = pulse_vals.size();
        send_str("12");
        send(8'h0D);
        send(8'h0A);
        check("t2_start", W'(out_start), W'(1));
        check("t2_num",   out_num,       W'(12));
        send_str("\n\n");
        repeat (25) @(negedge clk);
        check("t2_pulses", W'(pulse_vals.size() - base), W'(1));
        check("t2_sent",   W'(lines_sent),               W'(2));

        nines = '0;
        repeat (100) nines = nines * 10 + 9;
        send_rep("9", 100);
        send(8'h0A);
        check("t3_start",   W'(out_start),     W'(1));
        check("t3_num",     out_num,           nines);
        check("t3_dropped", W'(lines_dropped), W'(0));
        repeat (25) @(negedge clk);

        base = pulse_vals.size();
        send_rep("1", 101);
        send(8'h0A);
        check("t4_no_start", W'(out_start),     W'(0));
        check("t4_dropped",  W'(lines_dropped), W'(1));
        send_str("5\n");
        check("t4_start", W'(out_start), W'(1));
        check("t4_num",   out_num,       W'(5));
        repeat (25) @(negedge clk);
        check("t4_pulses", W'(pulse_vals.size() - base), W'(1));
        check("t4_sent",   W'(lines_sent),               W'(4));

        ds_delay    = 30;
        base        = pulse_vals.size();
        timing_base = base;
        send_str("3\n");
        check("t5_num3", out_num, W'(3));
        send_str("4\n");
        check("t5_hold_lf2", W'(in_ready), W'(0));
        send_str("7\n");
        check("t5_hold_lf3", W'(in_ready), W'(0));
        repeat (100) @(negedge clk);
        timing_base = -1;
        check("t5_pulses", W'(pulse_vals.size() - base), W'(3));
        if (pulse_vals.size() - base == 3) begin
            check("t5_p0", pulse_vals[base],     W'(3));
            check("t5_p1", pulse_vals[base + 1], W'(4));
            check("t5_p2", pulse_vals[base + 2], W'(7));
        end
        check("t5_sent", W'(lines_sent), W'(7));

        send_str("55");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("t6_rst_sent",    W'(lines_sent),    W'(0));
        check("t6_rst_dropped", W'(lines_dropped), W'(0));
        check("t6_rst_num",     out_num,           W'(0));
        check("t6_rst_ready",   W'(in_ready),      W'(1));
        send_str("8\n");
        check("t6_start", W'(out_start), W'(1));
        check("t6_num",   out_num,       W'(8));
        repeat (25) @(negedge clk);
        check("t6_sent", W'(lines_sent), W'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
